// File: rtl/stm1_demapper_pkg.sv
// Shared constants and types for the STM-1 receive demapper.
// Frame geometry defaults match the transmit-side C4/VC4/STM-1 mapping path.
package stm1_demapper_pkg;
  localparam int STM1_Length = 270;
  localparam int STM1_Width  = 9;
  localparam int c4_Length   = 260;
  localparam int c4_Width    = 9;

  localparam logic [7:0] A1_BYTE = 8'hF6;
  localparam logic [7:0] A2_BYTE = 8'h28;
  localparam int SOH_COLS   = 9;
  localparam int POH_COL    = 9;
  localparam int LOF_THRESH = 4;

  localparam logic [47:0] FA_WORD = {A1_BYTE, A1_BYTE, A1_BYTE, A2_BYTE, A2_BYTE, A2_BYTE};

  typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} stm1_fa_state_t;
endpackage

// File: rtl/stm1_frame_aligner.sv
// A1/A2 frame alignment: framing FSM, row/col position counters and error counter.
// row/col always give the position of the byte currently offered on in_data.
module stm1_frame_aligner
  import stm1_demapper_pkg::stm1_fa_state_t, stm1_demapper_pkg::FA_WORD,
         stm1_demapper_pkg::HUNT, stm1_demapper_pkg::PRESYNC, stm1_demapper_pkg::SYNC;
#(
  parameter int STM1_LEN   = stm1_demapper_pkg::STM1_Length,
  parameter int STM1_ROWS  = stm1_demapper_pkg::STM1_Width,
  parameter int LOF_THRESH = stm1_demapper_pkg::LOF_THRESH,
  localparam int COL_W     = $clog2(STM1_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_sync,
  output logic [3:0]           row,
  output logic [COL_W-1:0]     col,
  output logic                 fa_err,
  output stm1_fa_state_t       fa_state
);
  localparam int ERR_W = $clog2(LOF_THRESH + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(STM1_LEN - 1);
  localparam logic [3:0]       LAST_ROW = 4'(STM1_ROWS - 1);

  stm1_fa_state_t   state_q, state_d;
  // Holds the five previous bytes; the sixth is the byte on in_data now.
  logic [39:0]      sreg;
  logic [COL_W-1:0] col_q;
  logic [3:0]       row_q;
  logic [ERR_W-1:0] err_q;
  logic             match, at_check, err_hit;

  assign match    = ({sreg, in_data} == FA_WORD);
  assign at_check = (row_q == 4'd0) && (col_q == COL_W'(5));
  assign err_hit  = (int'(err_q) + 1) >= LOF_THRESH;

  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      unique case (state_q)
        HUNT:    if (match) state_d = PRESYNC;
        PRESYNC: if (at_check) state_d = match ? SYNC : HUNT;
        SYNC:    if (at_check && !match && err_hit) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sreg    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= '0;
      fa_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      fa_err  <= in_valid && (state_q == SYNC) && at_check && !match;
      if (in_valid) begin
        sreg <= {sreg[31:0], in_data};
        // A hunt hit means the current byte is row 0 / col 5.
        if ((state_q == HUNT) && match) begin
          row_q <= 4'd0;
          col_q <= COL_W'(6);
        end else if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
        end else begin
          col_q <= col_q + COL_W'(1);
        end
        if (state_q != SYNC)
          err_q <= '0;
        else if (at_check)
          err_q <= (match || err_hit) ? '0 : err_q + ERR_W'(1);
      end
    end
  end

  assign in_sync  = (state_q == SYNC);
  assign row      = row_q;
  assign col      = col_q;
  assign fa_state = state_q;
endmodule

// File: rtl/stm1_demapper.sv
// STM-1 to C4 demapper: aligns on A1/A2, drops SOH columns, splits POH and C4 payload.
// in_valid has no ready: every in_valid byte is consumed that cycle, and each output strobe is a one-cycle valid.
module stm1_demapper
  import stm1_demapper_pkg::stm1_fa_state_t;
#(
  parameter int STM1_LEN   = stm1_demapper_pkg::STM1_Length,
  parameter int STM1_ROWS  = stm1_demapper_pkg::STM1_Width,
  parameter int SOH_COLS   = stm1_demapper_pkg::SOH_COLS,
  parameter int LOF_THRESH = stm1_demapper_pkg::LOF_THRESH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           out_valid,
  output logic [7:0]     out_data,
  output logic           out_sof,
  output logic           out_sor,
  output logic           poh_valid,
  output logic [7:0]     poh_data,
  output logic [3:0]     poh_row,
  output logic           lof,
  output logic           fa_err,
  output stm1_fa_state_t fa_state
);
  localparam int COL_W = $clog2(STM1_LEN);
  localparam logic [COL_W-1:0] POH_C   = COL_W'(SOH_COLS);
  localparam logic [COL_W-1:0] FIRST_C = COL_W'(SOH_COLS + 1);

  logic             in_sync;
  logic [3:0]       row;
  logic [COL_W-1:0] col;
  logic             take_poh, take_pay;

  stm1_frame_aligner #(
    .STM1_LEN   (STM1_LEN),
    .STM1_ROWS  (STM1_ROWS),
    .LOF_THRESH (LOF_THRESH)
  ) u_aligner (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sync  (in_sync),
    .row      (row),
    .col      (col),
    .fa_err   (fa_err),
    .fa_state (fa_state)
  );

  assign take_poh = in_valid && in_sync && (col == POH_C);
  assign take_pay = in_valid && in_sync && (col > POH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_sor   <= 1'b0;
      poh_valid <= 1'b0;
      poh_data  <= '0;
      poh_row   <= '0;
    end else begin
      out_valid <= take_pay;
      out_sor   <= take_pay && (col == FIRST_C);
      out_sof   <= take_pay && (col == FIRST_C) && (row == 4'd0);
      poh_valid <= take_poh;
      if (take_pay) out_data <= in_data;
      if (take_poh) begin
        poh_data <= in_data;
        poh_row  <= row;
      end
    end
  end

  assign lof = !in_sync;
endmodule
